// File: rtl/icache_req_arbiter_mc.sv
// N-channel request arbiter feeding the icache tag pipeline: starvation override, registered output.
// Define ICACHE_ARB_RR_EN to use round-robin as the base policy; by default the base policy is fixed priority.
module icache_req_arbiter_mc #(
  parameter  int NUM_CH        = 4,
  parameter  int ADDR_W        = 33,
  parameter  int OPC_W         = 4,
  parameter  int TXNID_W       = 8,
  parameter  int STARVE_THRESH = 7,
  localparam int SRC_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_CH-1:0]         req_vld_i,
  output logic [NUM_CH-1:0]         req_rdy_o,
  input  logic [NUM_CH*OPC_W-1:0]   req_opcode_i,
  input  logic [NUM_CH*TXNID_W-1:0] req_txnid_i,
  input  logic [NUM_CH*ADDR_W-1:0]  req_addr_i,
  output logic                      tag_req_vld_o,
  input  logic                      tagram_req_rdy_i,
  input  logic                      mshr_tag_req_rdy_i,
  output logic [OPC_W-1:0]          tag_req_opcode_o,
  output logic [TXNID_W-1:0]        tag_req_txnid_o,
  output logic [ADDR_W-1:0]         tag_req_addr_o,
  output logic [SRC_W-1:0]          tag_req_src_o
);

  logic                out_rdy;
  logic                load;
  logic                any_vld;
  logic [NUM_CH-1:0]   starved;
  logic [NUM_CH-1:0]   gnt;
  logic                starve_any;
  logic [SRC_W-1:0]    starve_idx;
  logic [SRC_W-1:0]    base_idx;
  logic [SRC_W-1:0]    gnt_idx;

  logic                vld_q,  vld_d;
  logic [OPC_W-1:0]    opc_q,  opc_d;
  logic [TXNID_W-1:0]  txn_q,  txn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SRC_W-1:0]    src_q,  src_d;

  // The output register accepts a new beat whenever it is empty or draining this cycle.
  assign out_rdy = tagram_req_rdy_i & mshr_tag_req_rdy_i;
  assign load    = ~vld_q | out_rdy;
  assign any_vld = |req_vld_i;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    starve_any = 1'b0;
    starve_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (starved[i]) begin
        starve_any = 1'b1;
        starve_idx = SRC_W'(i);
      end
    end
  end

`ifdef ICACHE_ARB_RR_EN
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W:0]   rr_sum;

  // Walk the ring downwards in distance so the channel closest to ptr is left as the winner.
  always_comb begin
    base_idx = '0;
    rr_sum   = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      rr_sum = {1'b0, ptr_q} + (SRC_W+1)'(off);
      if (rr_sum >= (SRC_W+1)'(NUM_CH)) rr_sum = rr_sum - (SRC_W+1)'(NUM_CH);
      if (req_vld_i[rr_sum[SRC_W-1:0]]) base_idx = rr_sum[SRC_W-1:0];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|req_rdy_o) ptr_d = (gnt_idx == SRC_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    base_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_vld_i[i]) base_idx = SRC_W'(i);
    end
  end
`endif

  assign gnt_idx   = starve_any ? starve_idx : base_idx;
  assign gnt       = any_vld ? (NUM_CH'(1) << gnt_idx) : '0;
  // Reset gates the accept so requesters never see a handshake that the register then drops.
  assign req_rdy_o = gnt & {NUM_CH{load & ~rst_i}};

  if (NUM_CH > 1) begin : g_starve
    logic [7:0] cnt_q [NUM_CH];
    logic [7:0] cnt_d [NUM_CH];
    logic       accept_any;

    assign accept_any = |req_rdy_o;

    // A loss is counted only on a real accept of another channel; output stalls freeze the count.
    always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_d[i] = cnt_q[i];
        if (!req_vld_i[i] || req_rdy_o[i]) begin
          cnt_d[i] = '0;
        end else if (accept_any && (cnt_q[i] < 8'(STARVE_THRESH))) begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end

    // NOTE: this small counter array is reset element by element; it steers grants, so it must
    // never start from an unknown value (unlike a data RAM, which would be left unreset).
    always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rst_i) cnt_q[i] <= '0;
        else       cnt_q[i] <= cnt_d[i];
      end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flag
      assign starved[g] = req_vld_i[g] & (cnt_q[g] == 8'(STARVE_THRESH));
    end
  end else begin : g_no_starve
    assign starved = '0;
  end

  // Payload select is an AND-OR over the one-hot grant; the register holds when nothing is valid.
  always_comb begin
    vld_d  = vld_q;
    opc_d  = opc_q;
    txn_d  = txn_q;
    addr_d = addr_q;
    src_d  = src_q;
    if (load) begin
      vld_d = any_vld;
      if (any_vld) begin
        opc_d  = '0;
        txn_d  = '0;
        addr_d = '0;
        src_d  = gnt_idx;
        for (int i = 0; i < NUM_CH; i++) begin
          if (gnt[i]) begin
            opc_d  = opc_d  | req_opcode_i[i*OPC_W +: OPC_W];
            txn_d  = txn_d  | req_txnid_i[i*TXNID_W +: TXNID_W];
            addr_d = addr_d | req_addr_i[i*ADDR_W +: ADDR_W];
          end
        end
      end
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      opc_q  <= '0;
      txn_q  <= '0;
      addr_q <= '0;
      src_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      opc_q  <= opc_d;
      txn_q  <= txn_d;
      addr_q <= addr_d;
      src_q  <= src_d;
    end
  end

  assign tag_req_vld_o    = vld_q;
  assign tag_req_opcode_o = opc_q;
  assign tag_req_txnid_o  = txn_q;
  assign tag_req_addr_o   = addr_q;
  assign tag_req_src_o    = src_q;

endmodule

// File: tb/tb_icache_req_arbiter_mc.sv
// Bench for icache_req_arbiter_mc: behavioural grant model plus output scoreboard and directed sequences.
module tb_icache_req_arbiter_mc;
  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 33;
  localparam int OPC_W   = 4;
  localparam int TXNID_W = 8;
  localparam int THRESH  = 7;
  localparam int SRC_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_CH-1:0]         req_vld;
  logic [NUM_CH-1:0]         req_rdy;
  logic [NUM_CH*OPC_W-1:0]   req_opcode;
  logic [NUM_CH*TXNID_W-1:0] req_txnid;
  logic [NUM_CH*ADDR_W-1:0]  req_addr;
  logic                      tag_req_vld;
  logic                      tagram_req_rdy;
  logic                      mshr_tag_req_rdy;
  logic [OPC_W-1:0]          tag_req_opcode;
  logic [TXNID_W-1:0]        tag_req_txnid;
  logic [ADDR_W-1:0]         tag_req_addr;
  logic [SRC_W-1:0]          tag_req_src;

  always #5 clk = ~clk;

  icache_req_arbiter_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .TXNID_W(TXNID_W), .STARVE_THRESH(THRESH)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_vld_i          (req_vld),
    .req_rdy_o          (req_rdy),
    .req_opcode_i       (req_opcode),
    .req_txnid_i        (req_txnid),
    .req_addr_i         (req_addr),
    .tag_req_vld_o      (tag_req_vld),
    .tagram_req_rdy_i   (tagram_req_rdy),
    .mshr_tag_req_rdy_i (mshr_tag_req_rdy),
    .tag_req_opcode_o   (tag_req_opcode),
    .tag_req_txnid_o    (tag_req_txnid),
    .tag_req_addr_o     (tag_req_addr),
    .tag_req_src_o      (tag_req_src)
  );

  typedef struct packed {
    logic [SRC_W-1:0]   src;
    logic [OPC_W-1:0]   opc;
    logic [TXNID_W-1:0] txn;
    logic [ADDR_W-1:0]  addr;
  } beat_t;

  beat_t             sb_q[$];
  int                acc_log[$];
  int                xfer_cnt = 0;
  int                err_cnt  = 0;
  int                chk_cnt  = 0;
  int                m_cnt[NUM_CH];
  int                m_ptr    = 0;
  logic              m_vld    = 1'b0;
  logic [TXNID_W-1:0] next_txn = '0;
  logic [NUM_CH-1:0] last_acc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Starved channels first by index, then the base policy.
  function automatic int model_pick(input logic [NUM_CH-1:0] v);
    for (int i = 0; i < NUM_CH; i++) if (v[i] && m_cnt[i] >= THRESH) return i;
`ifdef ICACHE_ARB_RR_EN
    for (int k = 0; k < NUM_CH; k++) begin
      int j;
      j = (m_ptr + k) % NUM_CH;
      if (v[j]) return j;
    end
`else
    for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic new_payload(input int ch);
    logic [63:0] r;
    r = {$urandom, $urandom};
    req_opcode[ch*OPC_W +: OPC_W]   = OPC_W'($urandom);
    req_txnid[ch*TXNID_W +: TXNID_W] = next_txn;
    req_addr[ch*ADDR_W +: ADDR_W]   = r[ADDR_W-1:0];
    next_txn = next_txn + 1'b1;
  endtask

  // One clock: sample accepts late in the cycle, then refresh accepted payloads after the edge.
  task automatic tick();
    #2;
    last_acc = req_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) if (last_acc[i]) new_payload(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_vld = '0;
    tagram_req_rdy = 1'b1;
    mshr_tag_req_rdy = 1'b1;
    tick();
    tick();
  endtask

  task automatic monitor_cycle();
    logic              out_rdy;
    logic              load;
    int                pick;
    logic [NUM_CH-1:0] exp_rdy;
    beat_t             act_b;
    beat_t             nb;
    out_rdy = tagram_req_rdy & mshr_tag_req_rdy;
    check("out_vld", 64'(tag_req_vld), 64'(m_vld));
    if (m_vld) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 64'(0), 64'(1));
      end else begin
        act_b = '{src: tag_req_src, opc: tag_req_opcode, txn: tag_req_txnid, addr: tag_req_addr};
        check("beat", 64'(act_b), 64'(sb_q[0]));
        if (out_rdy) begin
          void'(sb_q.pop_front());
          xfer_cnt++;
        end
      end
    end
    load    = !m_vld || out_rdy;
    pick    = (rst || !load) ? -1 : model_pick(req_vld);
    exp_rdy = (pick >= 0) ? NUM_CH'(1) << pick : '0;
    check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    for (int i = 0; i < NUM_CH; i++) if (req_rdy[i]) acc_log.push_back(i);
    if (rst) begin
      m_vld = 1'b0;
      m_ptr = 0;
      sb_q.delete();
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    end else if (load) begin
      m_vld = |req_vld;
      if (pick >= 0) begin
        nb.src  = SRC_W'(pick);
        nb.opc  = req_opcode[pick*OPC_W +: OPC_W];
        nb.txn  = req_txnid[pick*TXNID_W +: TXNID_W];
        nb.addr = req_addr[pick*ADDR_W +: ADDR_W];
        sb_q.push_back(nb);
        m_ptr = (pick + 1) % NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!req_vld[i] || i == pick) m_cnt[i] = 0;
        else if (pick >= 0 && m_cnt[i] < THRESH) m_cnt[i]++;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) if (!req_vld[i]) m_cnt[i] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      monitor_cycle();
    end
  end

  int a0;
  int x0;
`ifdef ICACHE_ARB_RR_EN
  int starve_exp[16] = '{0,3,0,3,0,3,0,3,0,3,0,3,0,3,0,3};
  int allst_exp[10]  = '{0,1,2,3,0,1,2,3,0,1};
`else
  int starve_exp[16] = '{0,0,0,0,0,0,0,3,0,0,0,0,0,0,0,3};
  int allst_exp[10]  = '{0,0,0,0,0,0,0,1,2,3};
`endif

  initial begin
    rst = 1'b1;
    req_vld = '1;
    tagram_req_rdy = 1'b1;
    mshr_tag_req_rdy = 1'b1;
    req_opcode = '0;
    req_txnid = '0;
    req_addr = '0;
    for (int i = 0; i < NUM_CH; i++) new_payload(i);

    // Reset held two cycles with every channel requesting.
    tick();
    tick();
    check("rst_no_acc", 64'(acc_log.size()), 64'(0));
    rst = 1'b0;
    tick();
    check("first_acc_cnt", 64'(acc_log.size()), 64'(1));
    check("first_acc_ch", 64'(acc_log[0]), 64'(0));
    drain();

    // Streaming from channel 1 alone.
    a0 = acc_log.size();
    x0 = xfer_cnt;
    req_vld = 4'b0010;
    repeat (8) tick();
    drain();
    check("stream_acc", 64'(acc_log.size() - a0), 64'(8));
    check("stream_xfer", 64'(xfer_cnt - x0), 64'(8));
    for (int k = 0; k < 8; k++) check("stream_src", 64'(acc_log[a0+k]), 64'(1));

    // Backpressure with a beat held in the output register.
    a0 = acc_log.size();
    x0 = xfer_cnt;
    req_vld = 4'b0100;
    tick();
    tagram_req_rdy = 1'b0;
    repeat (5) tick();
    check("bp_acc", 64'(acc_log.size() - a0), 64'(1));
    check("bp_xfer", 64'(xfer_cnt - x0), 64'(0));
    tagram_req_rdy = 1'b1;
    tick();
    check("bp_release", 64'(xfer_cnt - x0), 64'(1));
    drain();
    check("bp_total", 64'(xfer_cnt - x0), 64'(2));

    // Starvation of channel 3 behind channel 0, with a stall between the two rounds.
    do_reset();
    a0 = acc_log.size();
    req_vld = 4'b1001;
    repeat (8) tick();
    tagram_req_rdy = 1'b0;
    repeat (4) tick();
    tagram_req_rdy = 1'b1;
    repeat (8) tick();
    drain();
    check("starve_cnt", 64'(acc_log.size() - a0), 64'(16));
    for (int k = 0; k < 16; k++) check("starve_order", 64'(acc_log[a0+k]), 64'(starve_exp[k]));

    // All channels requesting at once.
    do_reset();
    a0 = acc_log.size();
    req_vld = 4'b1111;
    repeat (10) tick();
    drain();
    for (int k = 0; k < 10; k++) check("allst_order", 64'(acc_log[a0+k]), 64'(allst_exp[k]));

    // MSHR ready toggling every cycle.
    a0 = acc_log.size();
    x0 = xfer_cnt;
    req_vld = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      mshr_tag_req_rdy = (c % 2 == 0);
      tick();
    end
    drain();
    check("pr_acc", 64'(acc_log.size() - a0), 64'(6));
    check("pr_xfer", 64'(xfer_cnt - x0), 64'(6));

    // Reset in the middle of a stall: the held beat is dropped and the requester retries.
    x0 = xfer_cnt;
    req_vld = 4'b0010;
    tick();
    tagram_req_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_stall_vld", 64'(tag_req_vld), 64'(0));
    rst = 1'b0;
    tagram_req_rdy = 1'b1;
    tick();
    drain();
    check("rst_stall_xfer", 64'(xfer_cnt - x0), 64'(1));

    // Random traffic: requests stay up until accepted, readies random.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (last_acc[i] && $urandom_range(0, 1) == 0) req_vld[i] = 1'b0;
        else if (!req_vld[i] && $urandom_range(0, 2) == 0) req_vld[i] = 1'b1;
      end
      tagram_req_rdy   = ($urandom_range(0, 3) != 0);
      mshr_tag_req_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
